// File: rtl/freelist.sv
// Physical-register free list: circular buffer of free tags with four-wide pop,
// compacting four-wide release, and branch snapshots of the head pointer for recovery.
module freelist #(
   parameter int unsigned WIDTH_REG = 7,
   parameter int unsigned WIDTH_BRM = 4,
   parameter int unsigned NARCH     = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   output logic [4*WIDTH_REG-1:0]   o_prd4x,
   output logic                     o_ready,
   output logic [WIDTH_REG:0]       o_count,
   output logic                     o_err,
   input  logic                     i_req,
   input  logic [4*WIDTH_REG-1:0]   i_com_prd4x,
   input  logic                     i_com_en,
   input  logic                     i_snap,
   input  logic [WIDTH_BRM-1:0]     i_snap_tag,
   input  logic [WIDTH_BRM:0]       i_kill
);

   localparam int unsigned SIZE  = 1 << WIDTH_REG;
   localparam int unsigned NSNAP = 1 << WIDTH_BRM;
   localparam int unsigned PW    = WIDTH_REG + 1;
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned NFREE = SIZE - NARCH;
   localparam int unsigned LANES = 4;

   logic [WIDTH_REG-1:0] mem  [SIZE];
   logic [PW-1:0]        snap [NSNAP];

   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;
   logic [PW-1:0]        count;
   logic [PW-1:0]        head_pop;
   logic [PW-1:0]        head_next;
   logic [PW-1:0]        tail_next;
   logic                 err;

   logic                 kill_en;
   logic [WIDTH_BRM-1:0] kill_tag;
   logic                 pop;
   logic                 overflow;
   logic [CW-1:0]        count_after;

   logic [WIDTH_REG-1:0] lane_tag [LANES];
   logic [LANES-1:0]     lane_vld;
   logic [2:0]           lane_off [LANES];
   logic [2:0]           npush;

   assign kill_en  = i_kill[WIDTH_BRM];
   assign kill_tag = i_kill[WIDTH_BRM-1:0];

   assign count    = tail - head;
   assign o_count  = count;
   assign o_ready  = (count >= PW'(4));
   assign o_err    = err;

   // A kill takes priority over dispatch: the popped tags belong to the squashed path.
   assign pop      = i_req & o_ready & ~kill_en;
   assign head_pop = pop ? head + PW'(4) : head;

   // Compact the nonzero release lanes: each valid lane's slot offset is the number of valid lanes below it.
   always_comb begin
      npush = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_tag[i] = i_com_prd4x[i*WIDTH_REG +: WIDTH_REG];
         lane_vld[i] = i_com_en && (lane_tag[i] != '0);
         lane_off[i] = npush;
         npush       = npush + 3'(lane_vld[i]);
      end
   end

   // Occupancy check one bit wider than the pointers so a full list plus pushes cannot alias.
   always_comb begin
      count_after = {1'b0, count} + CW'(npush);
      if (pop) begin
         count_after = count_after - CW'(4);
      end
      overflow = (count_after > CW'(SIZE));
   end

   always_comb begin
      head_next = head_pop;
      if (kill_en) begin
         head_next = snap[kill_tag];
      end
      tail_next = tail;
      if (!overflow) begin
         tail_next = tail + PW'(npush);
      end
   end

   // Rename lanes read straight from storage at head..head+3, wrapping on the low pointer bits.
   always_comb begin
      o_prd4x = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         o_prd4x[i*WIDTH_REG +: WIDTH_REG] = mem[WIDTH_REG'(head[WIDTH_REG-1:0] + WIDTH_REG'(i))];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         head <= '0;
         tail <= PW'(NFREE);
         err  <= 1'b0;
      end else begin
         head <= head_next;
         tail <= tail_next;
         if (overflow) begin
            err <= 1'b1;
         end
      end
   end

   // Snapshot records the head as it will be after this cycle's dispatch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned s = 0; s < NSNAP; s++) begin
            snap[s] <= '0;
         end
      end else if (i_snap && !kill_en) begin
         snap[i_snap_tag] <= head_pop;
      end
   end

   // At reset the list holds every tag above the architectural set; the unused tail slots read as zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned k = 0; k < SIZE; k++) begin
            if (k < NFREE) begin
               mem[k] <= WIDTH_REG'(NARCH + k);
            end else begin
               mem[k] <= '0;
            end
         end
      end else if (!overflow) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_vld[i]) begin
               mem[WIDTH_REG'(tail[WIDTH_REG-1:0] + WIDTH_REG'(lane_off[i]))] <= lane_tag[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: directed scenarios plus random traffic checked against a
// pointer/array reference model of the free list.
module tb_freelist;

   localparam int WR    = 7;
   localparam int WB    = 4;
   localparam int NARCH = 32;
   localparam int SIZE  = 1 << WR;
   localparam int MASK  = 2 * SIZE - 1;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [4*WR-1:0]   o_prd4x;
   logic              o_ready;
   logic [WR:0]       o_count;
   logic              o_err;
   logic              i_req;
   logic [4*WR-1:0]   i_com_prd4x;
   logic              i_com_en;
   logic              i_snap;
   logic [WB-1:0]     i_snap_tag;
   logic [WB:0]       i_kill;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model
   int m_mem  [SIZE];
   int m_snap [1 << WB];
   int m_head;
   int m_tail;
   bit m_err;

   freelist #(.WIDTH_REG(WR), .WIDTH_BRM(WB), .NARCH(NARCH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .o_prd4x     (o_prd4x),
      .o_ready     (o_ready),
      .o_count     (o_count),
      .o_err       (o_err),
      .i_req       (i_req),
      .i_com_prd4x (i_com_prd4x),
      .i_com_en    (i_com_en),
      .i_snap      (i_snap),
      .i_snap_tag  (i_snap_tag),
      .i_kill      (i_kill)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < SIZE; k++) m_mem[k] = (k < SIZE - NARCH) ? NARCH + k : 0;
      foreach (m_snap[s]) m_snap[s] = 0;
      m_head = 0;
      m_tail = SIZE - NARCH;
      m_err  = 1'b0;
   endfunction

   function automatic int m_count();
      return (m_tail - m_head) & MASK;
   endfunction

   // One clock of the free-list rules applied to the current inputs.
   function automatic void model_step();
      int cnt, nh, t;
      int pushes[$];
      bit kill, pop;
      if (i_rst) begin
         model_reset();
         return;
      end
      cnt  = m_count();
      kill = i_kill[WB];
      pop  = i_req && (cnt >= 4) && !kill;
      for (int i = 0; i < 4; i++) begin
         t = int'(i_com_prd4x[i*WR +: WR]);
         if (i_com_en && t != 0) pushes.push_back(t);
      end
      nh = pop ? (m_head + 4) & MASK : m_head;
      if (cnt - (pop ? 4 : 0) + pushes.size() > SIZE) begin
         m_err = 1'b1;
      end else begin
         foreach (pushes[k]) m_mem[(m_tail + k) % SIZE] = pushes[k];
         m_tail = (m_tail + pushes.size()) & MASK;
      end
      if (kill) nh = m_snap[int'(i_kill[WB-1:0])];
      else if (i_snap) m_snap[int'(i_snap_tag)] = nh;
      m_head = nh;
   endfunction

   task automatic tick();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_req       = 1'b0;
      i_com_en    = 1'b0;
      i_com_prd4x = '0;
      i_snap      = 1'b0;
      i_snap_tag  = '0;
      i_kill      = '0;
   endtask

   task automatic set_push(input int l0, input int l1, input int l2, input int l3);
      i_com_en    = 1'b1;
      i_com_prd4x = {WR'(l3), WR'(l2), WR'(l1), WR'(l0)};
   endtask

   task automatic do_reset();
      idle();
      i_rst = 1'b1;
      model_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int cnt;
      cnt = m_count();
      chk({tag, "_count"}, 64'(o_count), 64'(cnt));
      chk({tag, "_ready"}, 64'(o_ready), 64'(cnt >= 4));
      chk({tag, "_err"},   64'(o_err),   64'(m_err));
      if (cnt >= 4) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("%s_lane%0d", tag, i), 64'(o_prd4x[i*WR +: WR]),
                64'(m_mem[(m_head + i) % SIZE]));
      end
   endtask

   initial begin
      idle();
      i_rst = 1'b0;
      #2;
      do_reset();
      chk("rst_count", 64'(o_count), 64'd96);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_err",   64'(o_err),   64'd0);
      chk("rst_prd",   64'(o_prd4x), 64'({7'd35, 7'd34, 7'd33, 7'd32}));

      // single pop
      i_req = 1'b1;
      tick();
      idle();
      chk("pop1_prd",   64'(o_prd4x), 64'({7'd39, 7'd38, 7'd37, 7'd36}));
      chk("pop1_count", 64'(o_count), 64'd92);
      check_all("pop1");

      // drain to empty, ignored request, partial release
      do_reset();
      i_req = 1'b1;
      for (int c = 0; c < 24; c++) tick();
      chk("drain_count", 64'(o_count), 64'd0);
      chk("drain_ready", 64'(o_ready), 64'd0);
      tick();
      chk("empty_req_count", 64'(o_count), 64'd0);
      idle();
      set_push(7, 5, 0, 0);
      tick();
      idle();
      chk("rel2_count", 64'(o_count), 64'd2);
      chk("rel2_ready", 64'(o_ready), 64'd0);
      check_all("rel2");

      // snapshot then kill with a concurrent (discarded) pop
      do_reset();
      i_req = 1'b1; i_snap = 1'b1; i_snap_tag = 4'd3;
      tick();
      i_snap = 1'b0;
      tick();
      tick();
      i_kill = {1'b1, 4'd3};
      tick();
      idle();
      chk("kill_count", 64'(o_count), 64'd92);
      chk("kill_prd",   64'(o_prd4x), 64'({7'd39, 7'd38, 7'd37, 7'd36}));
      check_all("kill");

      // kill to an unwritten slot restores head 0
      i_kill = {1'b1, 4'd9};
      tick();
      idle();
      chk("kill_fresh_count", 64'(o_count), 64'd96);
      check_all("kill_fresh");

      // same-cycle pop and compacting push
      do_reset();
      i_req = 1'b1;
      set_push(0, 8, 0, 9);
      tick();
      idle();
      chk("pp_count", 64'(o_count), 64'd94);
      i_req = 1'b1;
      for (int c = 0; c < 23; c++) tick();
      idle();
      chk("pp_slot96", 64'(o_prd4x[WR-1:0]),  64'd8);
      chk("pp_slot97", 64'(o_prd4x[2*WR-1:WR]), 64'd9);

      // overflow is sticky and blocks the write
      do_reset();
      set_push(1, 2, 3, 4);
      for (int c = 0; c < 8; c++) tick();
      chk("fill_count", 64'(o_count), 64'd128);
      chk("fill_err",   64'(o_err),   64'd0);
      tick();
      idle();
      chk("ovf_err",   64'(o_err),   64'd1);
      chk("ovf_count", 64'(o_count), 64'd128);
      tick();
      chk("ovf_sticky", 64'(o_err), 64'd1);
      do_reset();
      chk("ovf_clear", 64'(o_err), 64'd0);

      // pop across the storage wrap
      i_req = 1'b1;
      for (int c = 0; c < 24; c++) tick();
      idle();
      for (int c = 0; c < 9; c++) begin
         set_push(4*c + 1, 4*c + 2, 4*c + 3, 4*c + 4);
         tick();
      end
      idle();
      i_req = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      idle();
      chk("wrap_count8", 64'(o_count), 64'd8);
      chk("wrap_prd124", 64'(o_prd4x), 64'({7'd32, 7'd31, 7'd30, 7'd29}));
      i_req = 1'b1;
      tick();
      chk("wrap_prd0", 64'(o_prd4x), 64'({7'd36, 7'd35, 7'd34, 7'd33}));
      tick();
      idle();
      chk("wrap_count0", 64'(o_count), 64'd0);
      check_all("wrap");

      // asynchronous reset mid-operation
      i_req = 1'b1;
      set_push(11, 12, 13, 14);
      #2;
      i_rst = 1'b1;
      model_reset();
      #1;
      chk("async_count", 64'(o_count), 64'd96);
      chk("async_prd",   64'(o_prd4x), 64'({7'd35, 7'd34, 7'd33, 7'd32}));
      idle();
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();
      check_all("async_after");

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         i_req    = 1'($urandom_range(0, 1));
         i_com_en = ($urandom_range(0, 9) < 4);
         for (int i = 0; i < 4; i++)
            i_com_prd4x[i*WR +: WR] = ($urandom_range(0, 1) == 1) ? WR'($urandom) : '0;
         i_snap     = ($urandom_range(0, 3) == 0);
         i_snap_tag = WB'($urandom);
         i_kill     = ($urandom_range(0, 29) == 0) ? {1'b1, WB'($urandom)} : '0;
         tick();
         check_all("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/freelist.md
FREELIST -- requirements
Module: freelist

Interface
REQ-001 SHALL have parameter WIDTH_REG, default 7, physical register tag width; depth SIZE = 2^WIDTH_REG entries.
REQ-002 SHALL have parameter WIDTH_BRM, default 4, branch tag width; snapshot slots NSNAP = 2^WIDTH_BRM.
REQ-003 SHALL have parameter NARCH, default 32, count of architecturally mapped physical registers at reset.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port o_prd4x, output, 4*WIDTH_REG, four free tags for rename; lane i at [(i+1)*WIDTH_REG-1:i*WIDTH_REG].
REQ-007 SHALL have port o_ready, output, 1, high when count >= 4.
REQ-008 SHALL have port o_count, output, WIDTH_REG+1, current number of free entries.
REQ-009 SHALL have port o_err, output, 1, sticky overflow flag.
REQ-010 SHALL have port i_req, input, 1, dispatch pops four tags.
REQ-011 SHALL have port i_com_prd4x, input, 4*WIDTH_REG, stale tags released at commit.
REQ-012 SHALL have port i_com_en, input, 1, commit qualifier for i_com_prd4x.
REQ-013 SHALL have port i_snap, input, 1, take a head snapshot.
REQ-014 SHALL have port i_snap_tag, input, WIDTH_BRM, snapshot slot index.
REQ-015 SHALL have port i_kill, input, WIDTH_BRM+1, {enkill, tag}; enkill is the MSB.

Function
REQ-016 Storage SHALL be a circular buffer of SIZE tags, with head/tail pointers of WIDTH_REG+1 bits (wrap bit in the MSB); count = tail - head, modulo 2^(WIDTH_REG+1).
REQ-017 o_prd4x lane i SHALL be combinational mem[(head+i) mod SIZE]; it is valid only while o_ready = 1.
REQ-018 Pop: i_req & o_ready & ~enkill SHALL advance head by 4 at the next edge; i_req while o_ready = 0 SHALL be ignored with no state change.
REQ-019 Push: when i_com_en = 1, every lane whose tag != 0 SHALL be written in lane order at consecutive slots starting at tail; tail SHALL advance by the number of nonzero lanes (0-4). Tag 0 means no release.
REQ-020 Push and pop in the same cycle SHALL both take effect; count_next = count + npush - 4*pop.
REQ-021 Overflow: if count - 4*pop + npush > SIZE, no entries SHALL be written, tail SHALL hold, and o_err SHALL set and stay high until reset.
REQ-022 Snapshot: i_snap SHALL store into slot i_snap_tag the head value after this cycle's pop.
REQ-023 Kill: enkill = 1 SHALL set head = snap[tag] at the next edge; a pop in the same cycle SHALL be discarded; a push in the same cycle SHALL still occur; i_snap in the same cycle SHALL be ignored.
REQ-024 Wrap-around: all pointer arithmetic SHALL be modulo 2^(WIDTH_REG+1); storage indexing SHALL use the low WIDTH_REG bits.
REQ-025 A kill to a snapshot slot never written since reset SHALL restore head = 0.

Reset
REQ-026 While i_rst = 1 (asynchronous): mem[k] = NARCH+k for k < SIZE-NARCH; head = 0; tail = SIZE-NARCH; all snapshots = 0; o_err = 0.
REQ-027 Reset values with defaults: o_count = 96, o_ready = 1, o_prd4x = {35,34,33,32}, o_err = 0.
REQ-028 Reset asserted mid-operation SHALL discard pending pops, pushes, and snapshots immediately, without waiting for a clock edge.

Verification
REQ-029 Reset, then one i_req -> next cycle o_prd4x = {39,38,37,36}, o_count = 92.
REQ-030 24 consecutive i_req -> o_count = 0, o_ready = 0; a further i_req -> no change; i_com_en with {0,0,5,7} -> o_count = 2, still not ready.
REQ-031 From reset: i_snap with tag 3 plus i_req; two more i_req; then i_kill = {1,3} with i_req -> head = 4, o_prd4x = {39,38,37,36}, o_count = 92.
REQ-032 Same-cycle i_req and i_com_en {9,0,8,0} from reset -> o_count = 94; entries 96 and 97 hold 8 and 9.
REQ-033 From reset, i_com_en with {1,2,3,4} (count 96+4 > 128 is false, accepted -> 100); repeat until > 128 -> o_err = 1, tail held; i_rst -> o_err = 0.
REQ-034 Pop across the wrap: head at 124, count 8 -> o_prd4x lanes read mem[124..127], next pop reads mem[0..3], o_count = 0 after both.
